// File: rtl/scpu_unified_mem_ctrl.sv
// Unified byte-wide memory shared by the serial CPU's instruction-fetch and data ports.
// Round-robin arbitration, one byte per cycle, little-endian word assembly, req/ack handshake.
module scpu_unified_mem_ctrl #(
    parameter int BYTE_W     = 8,
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 9,
    parameter int DEPTH      = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_ack,
    output logic [BYTE_W*WORD_BYTES-1:0] i_rdata,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic                         d_size,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [BYTE_W*WORD_BYTES-1:0] d_wdata,
    output logic                         d_ack,
    output logic [BYTE_W*WORD_BYTES-1:0] d_rdata,
    output logic                         busy
);

    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int BEAT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int EXT_W  = ADDR_W + BEAT_W + 1;
    localparam logic P_INSTR = 1'b0;
    localparam logic P_DATA  = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_ACK} state_t;

    state_t              r_state, w_next;
    logic                r_last_grant;
    logic                r_port;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [BEAT_W-1:0]   r_beat;
    logic [BEAT_W-1:0]   r_last_idx;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   r_shadow;
    logic [BYTE_W-1:0]   r_mem [DEPTH];

    logic                w_grant_d;
    logic                w_last_beat;
    logic [ADDR_W-1:0]   w_i_base;
    logic [ADDR_W-1:0]   w_d_base;
    logic [WORD_W-1:0]   w_merged;
    logic [BYTE_W-1:0]   w_wbyte;

    function automatic logic [ADDR_W-1:0] f_wrap(input logic [EXT_W-1:0] a);
        logic [EXT_W-1:0] m;
        m = a % EXT_W'(DEPTH);
        return m[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    // Data wins only when instruction is idle or was served last.
    assign w_grant_d   = d_req && (!i_req || (r_last_grant == P_INSTR));
    assign w_last_beat = (r_beat == r_last_idx);
    assign w_i_base    = f_wrap(EXT_W'(i_addr) * EXT_W'(WORD_BYTES));
    assign w_d_base    = f_wrap(EXT_W'(d_addr));
    assign w_wbyte     = r_wdata[r_beat*BYTE_W +: BYTE_W];

    always_comb begin
        w_merged = r_shadow;
        w_merged[r_beat*BYTE_W +: BYTE_W] = r_mem[r_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= P_DATA;
        end else begin
            r_state <= w_next;
            if (r_state == S_ACK) r_last_grant <= r_port;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_req || d_req) w_next = S_XFER;
            S_XFER:  if (w_last_beat)    w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != S_IDLE);
        i_ack = (r_state == S_ACK) && (r_port == P_INSTR);
        d_ack = (r_state == S_ACK) && (r_port == P_DATA);
    end

    // Grant latches the winner's request; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            r_port     <= w_grant_d;
            r_addr     <= w_grant_d ? w_d_base : w_i_base;
            r_beat     <= '0;
            r_last_idx <= (w_grant_d && !d_size) ? '0 : BEAT_W'(WORD_BYTES - 1);
            r_we       <= w_grant_d && d_we;
            r_wdata    <= d_wdata;
            r_shadow   <= '0;
        end else if (r_state == S_XFER) begin
            r_beat <= r_beat + 1'b1;
            r_addr <= f_next_addr(r_addr);
            if (!r_we) r_shadow <= w_merged;
        end
    end

    // Read data is published on the last beat so it is valid alongside ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if ((r_state == S_XFER) && w_last_beat && !r_we) begin
            if (r_port == P_DATA) d_rdata <= w_merged;
            else                  i_rdata <= w_merged;
        end
    end

    // A reset arriving mid-write blocks the beat in flight; earlier beats persist.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_XFER) && r_we) r_mem[r_addr] <= w_wbyte;
    end

endmodule

// File: tb/tb_scpu_unified_mem_ctrl.sv
// Directed bench for scpu_unified_mem_ctrl: preloads through the data port,
// then checks fetch, arbitration, byte/word access, wrap, reset abort and re-request.
module tb_scpu_unified_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, d_size;
    logic [8:0]  i_addr, d_addr;
    logic [15:0] d_wdata;
    logic        i_ack, d_ack, busy;
    logic [15:0] i_rdata, d_rdata;

    int checks   = 0;
    int failures = 0;
    logic both_acks = 1'b0;

    scpu_unified_mem_ctrl #(
        .BYTE_W(8), .WORD_BYTES(2), .ADDR_W(9), .DEPTH(512)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (i_ack && d_ack) both_acks = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge, drives in the following IDLE cycle, returns ack cycle (-1 on timeout).
    task automatic dtxn(input logic we, input logic sz, input logic [8:0] a,
                        input logic [15:0] wd, output int lat, output logic [15:0] rd);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        lat = -1; rd = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (d_ack) begin lat = c; rd = d_rdata; break; end
        end
        d_req = 1'b0;
    endtask

    task automatic itxn(input logic [8:0] a, output int lat, output logic [15:0] rd);
        @(negedge clk);
        i_req = 1'b1; i_addr = a;
        lat = -1; rd = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (i_ack) begin lat = c; rd = i_rdata; break; end
        end
        i_req = 1'b0;
    endtask

    task automatic pair(input logic [8:0] ia, input logic [8:0] da, output int ic, output int dc);
        @(negedge clk);
        i_req = 1'b1; i_addr = ia;
        d_req = 1'b1; d_we = 1'b0; d_size = 1'b1; d_addr = da;
        ic = -1; dc = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (i_ack) begin ic = c; i_req = 1'b0; end
            if (d_ack) begin dc = c; d_req = 1'b0; end
            if (ic >= 0 && dc >= 0) break;
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        int lat, ic, dc, lat2;
        logic [15:0] rd;

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_i_ack", i_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;

        // 1: preload [32]=00 [33]=3C, fetch word 16
        dtxn(1, 1, 9'd32, 16'h3C00, lat, rd);
        check("t1_wr_lat", lat, 3);
        itxn(9'd16, lat, rd);
        check("t1_fetch_lat", lat, 3);
        check("t1_fetch_data", rd, 16'h3C00);

        // 2: simultaneous requests, last grant was data
        dtxn(1, 1, 9'd0, 16'h00AB, lat, rd);
        pair(9'd16, 9'd0, ic, dc);
        check("t2a_i_cycle", ic, 3);
        check("t2a_d_cycle", dc, 7);
        check("t2a_d_rdata", d_rdata, 16'h00AB);
        check("t2a_i_rdata", i_rdata, 16'h3C00);
        itxn(9'd16, lat, rd);
        pair(9'd16, 9'd0, ic, dc);
        check("t2b_d_cycle", dc, 3);
        check("t2b_i_cycle", ic, 7);

        // 3: byte write leaves the upper neighbour alone
        dtxn(1, 1, 9'd4, 16'h5A11, lat, rd);
        dtxn(1, 0, 9'd4, 16'hBEEF, lat, rd);
        check("t3_bwr_lat", lat, 2);
        check("t3_wr_keeps_rdata", rd, 16'h00AB);
        dtxn(0, 1, 9'd4, 16'h0000, lat, rd);
        check("t3_rd_data", rd, 16'h5AEF);

        // 4: word write wrapping past the top of the array
        dtxn(1, 1, 9'd511, 16'h1234, lat, rd);
        dtxn(0, 1, 9'd511, 16'h0000, lat, rd);
        check("t4_wrap_rd", rd, 16'h1234);
        dtxn(0, 1, 9'd0, 16'h0000, lat, rd);
        check("t4_mem0", rd, 16'h0012);

        // 5: reset during beat 1 of a word write
        dtxn(1, 1, 9'd8, 16'h7766, lat, rd);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 1'b1; d_addr = 9'd8; d_wdata = 16'hCDEF;
        @(negedge clk);
        check("t5_busy_beat0", busy, 1);
        @(negedge clk);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check("t5_busy_after_rst", busy, 0);
        check("t5_no_ack", d_ack, 0);
        check("t5_rdata_cleared", d_rdata, 0);
        rst = 1'b0;
        dtxn(0, 1, 9'd8, 16'h0000, lat, rd);
        check("t5_after_lat", lat, 3);
        check("t5_partial_write", rd, 16'h77EF);

        // 6: byte read of FF, then hold the request for a second ack
        dtxn(1, 0, 9'd20, 16'h00FF, lat, rd);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_size = 1'b0; d_addr = 9'd20;
        lat = -1; lat2 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (d_ack) begin
                if (lat < 0) begin lat = c; rd = d_rdata; end
                else begin lat2 = c; break; end
            end
        end
        d_req = 1'b0;
        check("t6_byte_lat", lat, 2);
        check("t6_byte_data", rd, 16'h00FF);
        check("t6_reissue_cycle", lat2, 5);

        check("never_both_acks", both_acks, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
